wb_write_merge: RTL and testbench
=================================

# wb_write_merge

Writer-side front end for the 32x32 register file. Merges writebacks from the in-order pipeline writeback stage and the long-latency unit (multiply/divide and misses) into the register file's single write port (regwrite/writereg/writedata). Buffers long-latency results in a small FIFO and gives them slots the pipeline leaves idle, with a starvation guard. Provides a two-port lookup so decode can forward values that are still pending.

## Interface
Parameters:
- DEPTH, 4, long-latency FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 8, consecutive cycles a non-empty FIFO may go undrained before the pipeline is stalled

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous active-high reset
- pipe_wb_en  in  1  pipeline writeback valid; no handshake; must be low while pipe_stall=1
- pipe_wb_reg  in  5  pipeline destination register
- pipe_wb_data  in  32  pipeline result
- lu_valid  in  1  long-latency result valid
- lu_ready  out  1  FIFO can accept
- lu_reg  in  5  long-latency destination register
- lu_data  in  32  long-latency result
- pipe_stall  out  1  pipeline must hold its writeback this cycle
- regwrite  out  1  register file write enable
- writereg  out  5  register file write address
- writedata  out  32  register file write data
- fwd_reg1, fwd_reg2  in  5 each  lookup addresses from decode
- fwd_hit1, fwd_hit2  out  1 each  a pending write targets this register
- fwd_data1, fwd_data2  out  32 each  value the register will hold once all pending writes complete

## Operation
- Reset: FIFO empty, starvation counter 0, regwrite=0, writereg=0, writedata=0. lu_ready=0 and pipe_stall=0 while rst=1.
- lu_ready = !rst && count<DEPTH. It depends only on count, so a full FIFO stays not-ready even in a cycle where it dequeues.
- Handshake: an LU result is accepted on a posedge with lu_valid && lu_ready. lu_reg=0 completes the handshake but the entry is discarded.
- Output register, updated every posedge:
  - if pipe_wb_en && !pipe_stall && pipe_wb_reg!=0, load the pipeline write;
  - else if the FIFO is non-empty, pop the head into the output register;
  - else regwrite=0.
  - pipe_wb_en with reg 0 counts as an idle slot, so the FIFO may drain.
- Starvation counter:
  - increments when the FIFO is non-empty and not popped; clears on a pop or when empty; saturates at STARVE_LIMIT.
  - pipe_stall = (counter==STARVE_LIMIT), combinational from the counter.
  - A stall cycle always pops the head.
- Simultaneous enqueue and pop: both happen; count unchanged.
- Forwarding, combinational, per port:
  - address 0 returns hit=0, data=0;
  - otherwise the youngest matching FIFO entry wins;
  - if no FIFO entry matches, the output register wins if regwrite=1 and writereg matches;
  - otherwise hit=0, data=0.
  - Entries enqueued in the current cycle are not visible.
- Write ordering to the same register is preserved in issue order within each source. Ordering across sources is decode's responsibility, enforced via the forwarding lookup.
- rst asserted mid-operation drops all pending entries on the next posedge.

## Timing
- Pipeline write: sampled at edge N, regwrite high after N, register file written at edge N+1.
- LU write, minimum path: accepted at edge N, popped at edge N+1, register file written at edge N+2.
- Worst-case LU head wait: STARVE_LIMIT+1 cycles under a continuous pipeline write stream.
- Throughput: one register file write per cycle.

## Structure
- Shared package wb_pkg:
  - REG_ADDR_W=5, XLEN=32
  - typedef wb_entry_t {reg addr; data}
- Sub-module wb_fifo: circular buffer with head/tail pointers and count. Exposes all entries, valid bits and age order so the parent can do the forwarding search.

## Test plan
- Reset, then idle: regwrite=0, lu_ready=1, pipe_stall=0, fwd_hit=0 for all addresses.
- pipe_wb_en with reg 5 = 0xDEADBEEF at edge N: regwrite=1, writereg=5 after N; forwarding for reg 5 hits in that cycle.
- LU writes reg 7 = 0x11 while the pipeline is idle: accepted at N, regwrite/writereg=7 after N+1. A second LU write of reg 7 = 0x22 queued behind it gives fwd_data=0x22.
- Pipeline writes every cycle with one LU entry queued: pipe_stall asserts after exactly 8 undrained cycles, the head pops that cycle, and pipe_stall deasserts the next cycle.
- Fill all 4 FIFO entries: lu_ready=0. It stays 0 during a pop cycle at full and returns to 1 one cycle later.
- Writes to reg 0 from either source: no regwrite, the LU handshake completes, no forwarding hit. Assert rst with 3 entries queued: FIFO empty and regwrite=0 after the next edge.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and widths for the register-file write merge block.
package wb_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_entry_t;
endpackage

// File: rtl/wb_write_merge_if.sv
// Writeback sources, register-file write port and forwarding lookup bundle.
interface wb_write_merge_if;
  import wb_pkg::*;

  logic                  pipe_wb_en;
  logic [REG_ADDR_W-1:0] pipe_wb_reg;
  logic [XLEN-1:0]       pipe_wb_data;
  logic                  lu_valid;
  logic                  lu_ready;
  logic [REG_ADDR_W-1:0] lu_reg;
  logic [XLEN-1:0]       lu_data;
  logic                  pipe_stall;
  logic                  regwrite;
  logic [REG_ADDR_W-1:0] writereg;
  logic [XLEN-1:0]       writedata;
  logic [REG_ADDR_W-1:0] fwd_reg1;
  logic [REG_ADDR_W-1:0] fwd_reg2;
  logic                  fwd_hit1;
  logic                  fwd_hit2;
  logic [XLEN-1:0]       fwd_data1;
  logic [XLEN-1:0]       fwd_data2;

  modport master (
    output pipe_wb_en, pipe_wb_reg, pipe_wb_data, lu_valid, lu_reg, lu_data,
           fwd_reg1, fwd_reg2,
    input  lu_ready, pipe_stall, regwrite, writereg, writedata,
           fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
  );

  modport slave (
    input  pipe_wb_en, pipe_wb_reg, pipe_wb_data, lu_valid, lu_reg, lu_data,
           fwd_reg1, fwd_reg2,
    output lu_ready, pipe_stall, regwrite, writereg, writedata,
           fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
  );
endinterface

// File: rtl/wb_fifo.sv
// Circular buffer for long-latency results; exposes every slot, its valid bit
// and the head pointer so the parent can search entries oldest-to-youngest.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  wb_entry_t                  i_entry,
  input  logic                       i_pop,
  output wb_entry_t                  o_head_entry,
  output wb_entry_t                  o_entries [DEPTH],
  output logic [DEPTH-1:0]           o_valid,
  output logic [$clog2(DEPTH)-1:0]   o_head,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int PW = $clog2(DEPTH);

  wb_entry_t       r_mem [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [PW:0]     r_count;
  logic [PW-1:0]   w_off;

  // Pointer, count and storage update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_tail] <= i_entry;
        r_tail        <= r_tail + {{(PW-1){1'b0}}, 1'b1};
      end
      if (i_pop) begin
        r_head <= r_head + {{(PW-1){1'b0}}, 1'b1};
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + {{PW{1'b0}}, 1'b1};
        2'b01:   r_count <= r_count - {{PW{1'b0}}, 1'b1};
        default: r_count <= r_count;
      endcase
    end
  end

  // A slot is live when its distance from the head is below the count.
  always_comb begin
    o_valid = '0;
    w_off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off      = PW'(i) - r_head;
      o_valid[i] = ({1'b0, w_off} < r_count);
    end
  end

  assign o_entries    = r_mem;
  assign o_head_entry = r_mem[r_head];
  assign o_head       = r_head;
  assign o_count      = r_count;
endmodule

// File: rtl/wb_write_merge.sv
// Merges pipeline and long-latency writebacks onto the single register-file
// write port, with a starvation guard and pending-write forwarding.
module wb_write_merge
  import wb_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic               clk,
  input logic               rst,
  wb_write_merge_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  wb_entry_t             w_head_entry;
  wb_entry_t             w_entries [DEPTH];
  logic [DEPTH-1:0]      w_valid;
  logic [PW-1:0]         w_head;
  logic [PW:0]           w_count;
  logic                  w_empty;
  logic                  w_pipe_take;
  logic                  w_pop;
  logic                  w_push;
  logic [PW-1:0]         w_idx;
  logic [REG_ADDR_W-1:0] w_q_reg [2];
  logic                  w_hit   [2];
  logic [XLEN-1:0]       w_fdata [2];

  logic                  r_regwrite;
  logic [REG_ADDR_W-1:0] r_writereg;
  logic [XLEN-1:0]       r_writedata;
  logic [SW-1:0]         r_starve;

  assign w_empty     = (w_count == '0);
  assign w_pipe_take = bus.pipe_wb_en && !bus.pipe_stall && (bus.pipe_wb_reg != '0);
  assign w_pop       = !w_pipe_take && !w_empty;
  // Writes to r0 still complete the handshake but never occupy a slot.
  assign w_push      = bus.lu_valid && bus.lu_ready && (bus.lu_reg != '0);

  assign bus.lu_ready   = !rst && (w_count < (PW+1)'(DEPTH));
  assign bus.pipe_stall = !rst && (r_starve == SW'(STARVE_LIMIT));

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_entry      ({bus.lu_reg, bus.lu_data}),
    .i_pop        (w_pop),
    .o_head_entry (w_head_entry),
    .o_entries    (w_entries),
    .o_valid      (w_valid),
    .o_head       (w_head),
    .o_count      (w_count)
  );

  // Register-file write port: pipeline has priority, FIFO fills idle slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_regwrite  <= 1'b0;
      r_writereg  <= '0;
      r_writedata <= '0;
    end else if (w_pipe_take) begin
      r_regwrite  <= 1'b1;
      r_writereg  <= bus.pipe_wb_reg;
      r_writedata <= bus.pipe_wb_data;
    end else if (w_pop) begin
      r_regwrite  <= 1'b1;
      r_writereg  <= w_head_entry.addr;
      r_writedata <= w_head_entry.data;
    end else begin
      r_regwrite  <= 1'b0;
    end
  end

  // Cycles the head has waited; saturates and forces a stall at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
    end else if (w_empty || w_pop) begin
      r_starve <= '0;
    end else if (r_starve != SW'(STARVE_LIMIT)) begin
      r_starve <= r_starve + {{(SW-1){1'b0}}, 1'b1};
    end else begin
      r_starve <= r_starve;
    end
  end

  assign w_q_reg[0] = bus.fwd_reg1;
  assign w_q_reg[1] = bus.fwd_reg2;

  // Walk oldest to youngest so the youngest FIFO match overrides earlier ones.
  always_comb begin
    w_idx = '0;
    for (int p = 0; p < 2; p++) begin
      w_hit[p]   = 1'b0;
      w_fdata[p] = '0;
      if (w_q_reg[p] != '0) begin
        for (int k = 0; k < DEPTH; k++) begin
          w_idx = w_head + PW'(k);
          if (w_valid[w_idx] && (w_entries[w_idx].addr == w_q_reg[p])) begin
            w_hit[p]   = 1'b1;
            w_fdata[p] = w_entries[w_idx].data;
          end else begin
            w_hit[p]   = w_hit[p];
          end
        end
        if (!w_hit[p] && r_regwrite && (r_writereg == w_q_reg[p])) begin
          w_hit[p]   = 1'b1;
          w_fdata[p] = r_writedata;
        end else begin
          w_hit[p]   = w_hit[p];
        end
      end else begin
        w_hit[p]   = 1'b0;
      end
    end
  end

  assign bus.regwrite  = r_regwrite;
  assign bus.writereg  = r_writereg;
  assign bus.writedata = r_writedata;
  assign bus.fwd_hit1  = w_hit[0];
  assign bus.fwd_hit2  = w_hit[1];
  assign bus.fwd_data1 = w_fdata[0];
  assign bus.fwd_data2 = w_fdata[1];
endmodule

// File: tb/tb_wb_write_merge.sv
// Directed plus randomized bench for wb_write_merge against a queue-based
// model of the merge, starvation and forwarding rules.
module tb_wb_write_merge;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  logic clk;
  logic rst;
  wb_write_merge_if bus();

  wb_write_merge #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ent_t        q[$];
  int          m_starve;
  logic        m_rw;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdata;
  int          n_cmp;
  int          n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] fwd_exp(input logic [4:0] a);
    if (a == 5'd0) return 33'd0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].r == a) return {1'b1, q[i].d};
    if (m_rw && m_wreg == a) return {1'b1, m_wdata};
    return 33'd0;
  endfunction

  task automatic check_fwd();
    logic [32:0] e1;
    logic [32:0] e2;
    e1 = fwd_exp(bus.fwd_reg1);
    e2 = fwd_exp(bus.fwd_reg2);
    chk("fwd_hit1", {31'd0, bus.fwd_hit1}, {31'd0, e1[32]});
    chk("fwd_data1", bus.fwd_data1, e1[31:0]);
    chk("fwd_hit2", {31'd0, bus.fwd_hit2}, {31'd0, e2[32]});
    chk("fwd_data2", bus.fwd_data2, e2[31:0]);
  endtask

  task automatic check_all();
    chk("regwrite", {31'd0, bus.regwrite}, {31'd0, m_rw});
    chk("writereg", {27'd0, bus.writereg}, {27'd0, m_wreg});
    chk("writedata", bus.writedata, m_wdata);
    chk("lu_ready", {31'd0, bus.lu_ready}, {31'd0, (!rst && q.size() < DEPTH)});
    chk("pipe_stall", {31'd0, bus.pipe_stall}, {31'd0, (!rst && m_starve == LIMIT)});
    check_fwd();
  endtask

  task automatic model_edge(input logic r, input logic en, input logic [4:0] pr,
                            input logic [31:0] pd, input logic lv, input logic [4:0] lr,
                            input logic [31:0] ld);
    bit stall;
    bit ready;
    bit take;
    bit pop;
    if (r) begin
      q.delete();
      m_starve = 0;
      m_rw     = 1'b0;
      m_wreg   = 5'd0;
      m_wdata  = 32'd0;
    end else begin
      stall = (m_starve == LIMIT);
      ready = (q.size() < DEPTH);
      take  = en && !stall && (pr != 5'd0);
      pop   = !take && (q.size() != 0);
      if (q.size() == 0 || pop) m_starve = 0;
      else if (m_starve < LIMIT) m_starve++;
      if (take) begin
        m_rw = 1'b1; m_wreg = pr; m_wdata = pd;
      end else if (pop) begin
        m_rw = 1'b1; m_wreg = q[0].r; m_wdata = q[0].d;
        void'(q.pop_front());
      end else begin
        m_rw = 1'b0;
      end
      if (lv && ready && lr != 5'd0) q.push_back('{lr, ld});
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, check at negedge.
  task automatic cyc(input logic r, input logic en, input logic [4:0] pr,
                     input logic [31:0] pd, input logic lv, input logic [4:0] lr,
                     input logic [31:0] ld);
    logic en_eff;
    en_eff = en && !(m_starve == LIMIT && !rst);
    rst = r;
    bus.pipe_wb_en = en_eff; bus.pipe_wb_reg = pr; bus.pipe_wb_data = pd;
    bus.lu_valid = lv; bus.lu_reg = lr; bus.lu_data = ld;
    @(posedge clk);
    model_edge(r, en_eff, pr, pd, lv, lr, ld);
    @(negedge clk);
    bus.fwd_reg1 = 5'($urandom_range(0, 7));
    bus.fwd_reg2 = (q.size() != 0) ? q[$].r : 5'($urandom_range(0, 31));
    #1;
    check_all();
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    int n;
    n_cmp = 0; n_err = 0;
    q.delete(); m_starve = 0; m_rw = 1'b0; m_wreg = 5'd0; m_wdata = 32'd0;
    rst = 1'b1;
    bus.pipe_wb_en = 1'b0; bus.pipe_wb_reg = 5'd0; bus.pipe_wb_data = 32'd0;
    bus.lu_valid = 1'b0; bus.lu_reg = 5'd0; bus.lu_data = 32'd0;
    bus.fwd_reg1 = 5'd0; bus.fwd_reg2 = 5'd0;

    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    idle();
    for (int a = 0; a < 32; a++) begin
      bus.fwd_reg1 = 5'(a); bus.fwd_reg2 = 5'(31 - a);
      #1;
      check_fwd();
    end

    // Pipeline write visible on the write port and through forwarding.
    cyc(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    bus.fwd_reg1 = 5'd5; #1;
    chk("pipe_regwrite", {31'd0, bus.regwrite}, 32'd1);
    chk("pipe_fwd5_hit", {31'd0, bus.fwd_hit1}, 32'd1);
    chk("pipe_fwd5_data", bus.fwd_data1, 32'hDEADBEEF);

    // LU write path and youngest-entry forwarding.
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h11);
    chk("lu_not_yet", {31'd0, bus.regwrite}, 32'd0);
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h22);
    bus.fwd_reg1 = 5'd7; #1;
    chk("lu_writereg", {27'd0, bus.writereg}, 32'd7);
    chk("lu_writedata", bus.writedata, 32'h11);
    chk("lu_fwd7_young", bus.fwd_data1, 32'h22);
    idle(); idle();

    // Starvation: one queued entry under a continuous pipeline stream.
    cyc(1'b0, 1'b1, 5'd3, 32'h333, 1'b1, 5'd9, 32'h999);
    n = 0;
    while (!bus.pipe_stall && n < 20) begin
      cyc(1'b0, 1'b1, 5'd3, 32'($urandom), 1'b0, 5'd0, 32'd0);
      n++;
    end
    chk("starve_cycles", 32'(n), 32'd8);
    cyc(1'b0, 1'b1, 5'd3, 32'h444, 1'b0, 5'd0, 32'd0);
    chk("stall_pop_reg", {27'd0, bus.writereg}, 32'd9);
    chk("stall_release", {31'd0, bus.pipe_stall}, 32'd0);
    idle(); idle();

    // Fill, then a pop at full: ready stays low until the following cycle.
    for (int i = 0; i < DEPTH; i++)
      cyc(1'b0, 1'b1, 5'd4, 32'(i), 1'b1, 5'(10 + i), 32'(100 + i));
    chk("full_ready", {31'd0, bus.lu_ready}, 32'd0);
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'h2020);
    chk("after_pop_ready", {31'd0, bus.lu_ready}, 32'd1);

    // Reset with three entries pending drops them all.
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("rst_regwrite", {31'd0, bus.regwrite}, 32'd0);
    idle();
    chk("post_rst_regwrite", {31'd0, bus.regwrite}, 32'd0);

    // Register 0 from either source.
    cyc(1'b0, 1'b1, 5'd0, 32'h5555, 1'b1, 5'd0, 32'h6666);
    chk("r0_regwrite", {31'd0, bus.regwrite}, 32'd0);
    idle();
    chk("r0_lu_dropped", {31'd0, bus.regwrite}, 32'd0);
    bus.fwd_reg1 = 5'd0; #1;
    chk("r0_fwd", {31'd0, bus.fwd_hit1}, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)),
          32'($urandom), ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), 32'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
